// File: rtl/obi_pkg.sv
// OBI bus configuration types.
// Holds the bus configuration record that sizes the OBI request payload and
// the default configuration used when a block is instantiated without one.
package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: 32,
        DataWidth: 32,
        IdWidth:   1
    };

endpackage

// File: rtl/relobi_pkg.sv
// Reliable-OBI helper functions for the A-channel "other" field protection.
// The "other" vector is {we, be, aid, a_optional}. It is split into up to
// four independent Hsiao SEC-DED segments, LSB first. Every segment has
// ceil(W/NumSegments) bits except the last one, which takes the remainder.
package relobi_pkg;

    import obi_pkg::*;

    // Width of {we, be, aid, a_optional}
    function automatic int unsigned relobi_a_other_width(obi_cfg_t cfg,
                                                         int unsigned opt_width = 1);
        return 1 + cfg.DataWidth / 8 + cfg.IdWidth + opt_width;
    endfunction

    // Smallest k with 2^(k-1) >= d + k
    function automatic int unsigned hsiao_parity_width(int unsigned d);
        for (int unsigned k = 2; k < 32; k++) begin
            if ((32'd1 << (k - 1)) >= d + k) begin
                return k;
            end
        end
        return 32;
    endfunction

    function automatic int unsigned relobi_a_other_seg_base(int unsigned w, int unsigned n);
        return (w + n - 1) / n;
    endfunction

    // Data width of segment seg; 0 flags a split that leaves the last slice empty
    function automatic int unsigned relobi_a_other_seg_width(int unsigned w, int unsigned n,
                                                             int unsigned seg);
        int unsigned base;
        base = relobi_a_other_seg_base(w, n);
        if (seg + 1 < n) begin
            return base;
        end
        if (base * (n - 1) >= w) begin
            return 0;
        end
        return w - base * (n - 1);
    endfunction

    function automatic int unsigned relobi_a_other_seg_offset(int unsigned w, int unsigned n,
                                                              int unsigned seg);
        return relobi_a_other_seg_base(w, n) * seg;
    endfunction

    // ECC bit offset of segment seg (sum of parity widths of the segments below it)
    function automatic int unsigned relobi_a_other_seg_ecc_offset(int unsigned w, int unsigned n,
                                                                  int unsigned seg);
        int unsigned acc;
        acc = 0;
        for (int unsigned s = 0; s < seg; s++) begin
            acc += hsiao_parity_width(relobi_a_other_seg_width(w, n, s));
        end
        return acc;
    endfunction

    function automatic int unsigned relobi_a_other_seg_ecc_width(obi_cfg_t cfg, int unsigned n,
                                                                 int unsigned opt_width = 1);
        return relobi_a_other_seg_ecc_offset(relobi_a_other_width(cfg, opt_width), n, n);
    endfunction

endpackage

// File: rtl/hsiao_ecc_enc.sv
// Hsiao SEC-DED parity generator.
// Ports:
//   data   [DataWidth-1:0]  word to protect
//   parity [ProtWidth-1:0]  check bits
// H-matrix columns are odd-weight (>= 3) ProtWidth-bit values, taken in order
// of increasing weight and, within one weight, increasing numeric value.
// Data bit i uses column i; parity bit j is the XOR of all data bits whose
// column has bit j set.
module hsiao_ecc_enc #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned ProtWidth = relobi_pkg::hsiao_parity_width(DataWidth)
) (
    input  logic [DataWidth-1:0] data,
    output logic [ProtWidth-1:0] parity
);

    function automatic logic [DataWidth-1:0][ProtWidth-1:0] gen_cols();
        logic [DataWidth-1:0][ProtWidth-1:0] cols;
        int n;
        int pop;
        cols = '0;
        n    = 0;
        for (int w = 3; w <= int'(ProtWidth); w += 2) begin
            for (int v = 0; v < (1 << ProtWidth); v++) begin
                pop = 0;
                for (int b = 0; b < int'(ProtWidth); b++) begin
                    pop += (v >> b) & 1;
                end
                if (pop == w && n < int'(DataWidth)) begin
                    cols[n] = v[ProtWidth-1:0];
                    n++;
                end
            end
        end
        return cols;
    endfunction

    localparam logic [DataWidth-1:0][ProtWidth-1:0] Cols = gen_cols();

    always_comb begin
        parity = '0;
        for (int i = 0; i < int'(DataWidth); i++) begin
            if (data[i]) begin
                parity ^= Cols[i];
            end
        end
    end

endmodule

// File: rtl/relobi_a_other_seg_enc.sv
// One protection segment of the A-channel "other" field.
// Ports:
//   data [SegWidth-1:0]  slice of the "other" vector
//   ecc  [EccWidth-1:0]  Hsiao parity of that slice (data bits are not repeated)
module relobi_a_other_seg_enc #(
    parameter int unsigned SegWidth = 1,
    parameter int unsigned EccWidth = relobi_pkg::hsiao_parity_width(SegWidth)
) (
    input  logic [SegWidth-1:0] data,
    output logic [EccWidth-1:0] ecc
);

    hsiao_ecc_enc #(
        .DataWidth (SegWidth),
        .ProtWidth (EccWidth)
    ) i_hsiao_ecc_enc (
        .data   (data),
        .parity (ecc)
    );

endmodule

// File: rtl/relobi_a_other_enc_pipe.sv
// A-channel "other" field ECC encoder with optional pipeline stage.
// Computes segmented Hsiao parity over {we, be, aid, a_optional} and forwards
// the payload with its ECC, either through one valid/ready register stage
// (PipeEn=1, latency 1, full throughput) or combinationally (PipeEn=0).
// A single-beat error injection can be armed: the next accepted beat carries
// other_ecc_o[0] inverted, and inj_done_o pulses when that beat is taken
// downstream.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i / gnt_o         upstream handshake
//   we_i, be_i, aid_i,
//   a_optional_i          upstream payload
//   inj_i                 arm one ECC error injection
//   req_o / gnt_i         downstream handshake
//   we_o, be_o, aid_o,
//   a_optional_o          downstream payload
//   other_ecc_o           segmented parity, segment 0 at the LSBs
//   inj_done_o            injected beat accepted downstream
module relobi_a_other_enc_pipe
    import relobi_pkg::*;
#(
    parameter obi_pkg::obi_cfg_t Cfg           = obi_pkg::ObiDefaultConfig,
    parameter type               a_optional_t  = logic,
    parameter int unsigned       NumSegments   = 1,
    parameter bit                PipeEn        = 1'b1,
    parameter int unsigned       OtherEccWidth =
        relobi_pkg::relobi_a_other_seg_ecc_width(Cfg, NumSegments, $bits(a_optional_t))
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    output logic                       gnt_o,
    input  logic                       we_i,
    input  logic [Cfg.DataWidth/8-1:0] be_i,
    input  logic [Cfg.IdWidth-1:0]     aid_i,
    input  a_optional_t                a_optional_i,
    input  logic                       inj_i,
    output logic                       req_o,
    input  logic                       gnt_i,
    output logic                       we_o,
    output logic [Cfg.DataWidth/8-1:0] be_o,
    output logic [Cfg.IdWidth-1:0]     aid_o,
    output a_optional_t                a_optional_o,
    output logic [OtherEccWidth-1:0]   other_ecc_o,
    output logic                       inj_done_o
);

    localparam int unsigned W = relobi_a_other_width(Cfg, $bits(a_optional_t));

    if (NumSegments < 1 || NumSegments > 4) begin : gen_bad_num_segments
        $fatal(1, "NumSegments must be within 1..4");
    end
    if (NumSegments > W
        || relobi_a_other_seg_width(W, NumSegments, NumSegments - 1) == 0) begin : gen_bad_split
        $fatal(1, "NumSegments does not split the other vector into non-empty slices");
    end
    if (OtherEccWidth != relobi_a_other_seg_ecc_offset(W, NumSegments, NumSegments))
    begin : gen_bad_ecc_width
        $fatal(1, "OtherEccWidth does not match the segment parity widths");
    end

    logic [W-1:0]             other_vec;
    logic [OtherEccWidth-1:0] ecc_calc;
    logic [OtherEccWidth-1:0] ecc_inj;
    logic                     armed_q;
    logic                     inject_now;
    logic                     hs_in;
    logic                     gnt_up;
    logic                     valid_out;
    logic                     mark_out;
    logic [W-1:0]             vec_out;
    logic [OtherEccWidth-1:0] ecc_out;

    assign other_vec = {we_i, be_i, aid_i, a_optional_i};

    for (genvar s = 0; s < NumSegments; s++) begin : gen_seg
        localparam int unsigned SegW   = relobi_a_other_seg_width(W, NumSegments, s);
        localparam int unsigned SegOff = relobi_a_other_seg_offset(W, NumSegments, s);
        localparam int unsigned EccW   = hsiao_parity_width(SegW);
        localparam int unsigned EccOff = relobi_a_other_seg_ecc_offset(W, NumSegments, s);

        relobi_a_other_seg_enc #(
            .SegWidth (SegW),
            .EccWidth (EccW)
        ) i_seg_enc (
            .data (other_vec[SegOff +: SegW]),
            .ecc  (ecc_calc[EccOff +: EccW])
        );
    end

    // An inj_i in the same cycle as the handshake marks that beat directly,
    // so the flag only needs to survive until the next accepted beat.
    assign inject_now = armed_q || inj_i;
    assign ecc_inj    = ecc_calc ^ OtherEccWidth'(inject_now);
    assign hs_in      = req_i && gnt_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed_q <= 1'b0;
        end else if (hs_in) begin
            armed_q <= 1'b0;
        end else if (inj_i) begin
            armed_q <= 1'b1;
        end
    end

    if (PipeEn) begin : gen_pipe
        logic                     valid_q;
        logic                     mark_q;
        logic [W-1:0]             vec_q;
        logic [OtherEccWidth-1:0] ecc_q;

        // Load has priority: with gnt_i high gnt_o is high too, so a pending
        // req_i always replaces the departing entry in the same cycle.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                mark_q  <= 1'b0;
                vec_q   <= '0;
                ecc_q   <= '0;
            end else if (hs_in) begin
                valid_q <= 1'b1;
                mark_q  <= inject_now;
                vec_q   <= other_vec;
                ecc_q   <= ecc_inj;
            end else if (gnt_i) begin
                valid_q <= 1'b0;
            end
        end

        assign gnt_up    = !valid_q || gnt_i;
        assign valid_out = valid_q;
        assign mark_out  = mark_q;
        assign vec_out   = vec_q;
        assign ecc_out   = ecc_q;
    end else begin : gen_pass
        assign gnt_up    = gnt_i;
        assign valid_out = req_i;
        assign mark_out  = inject_now;
        assign vec_out   = rst_i ? '0 : other_vec;
        assign ecc_out   = rst_i ? '0 : ecc_inj;
    end

    // Reset also forces the handshake outputs, so nothing moves while it is held.
    assign req_o      = valid_out && !rst_i;
    assign gnt_o      = gnt_up || rst_i;
    assign inj_done_o = req_o && gnt_i && mark_out;

    assign {we_o, be_o, aid_o, a_optional_o} = vec_out;
    assign other_ecc_o                       = ecc_out;

endmodule

// File: tb/tb_relobi_a_other_enc_pipe.sv
module tb_relobi_a_other_enc_pipe;

    localparam obi_pkg::obi_cfg_t TbCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

    logic       clk;
    logic       rst;
    logic       req;
    logic       we;
    logic [3:0] be;
    logic [3:0] aid;
    logic       opt;
    logic       inj;
    logic       gnt;

    // u_dut1: 1 segment, piped
    logic       gnt1, req1, we1, opt1, done1;
    logic [3:0] be1, aid1;
    logic [4:0] ecc1;
    // u_dut2: 2 segments, piped
    logic       gnt2, req2, we2, opt2, done2;
    logic [3:0] be2, aid2;
    logic [9:0] ecc2;
    // u_dut0: 1 segment, combinational
    logic       gnt0, req0, we0, opt0, done0;
    logic [3:0] be0, aid0;
    logic [4:0] ecc0;

    int n_chk  = 0;
    int n_fail = 0;
    int n_hs1  = 0;
    int hs0;

    relobi_a_other_enc_pipe #(.Cfg(TbCfg), .a_optional_t(logic), .NumSegments(1), .PipeEn(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .we_i(we), .be_i(be), .aid_i(aid),
        .a_optional_i(opt), .inj_i(inj), .req_o(req1), .gnt_i(gnt), .we_o(we1), .be_o(be1),
        .aid_o(aid1), .a_optional_o(opt1), .other_ecc_o(ecc1), .inj_done_o(done1)
    );

    relobi_a_other_enc_pipe #(.Cfg(TbCfg), .a_optional_t(logic), .NumSegments(2), .PipeEn(1'b1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt2), .we_i(we), .be_i(be), .aid_i(aid),
        .a_optional_i(opt), .inj_i(inj), .req_o(req2), .gnt_i(gnt), .we_o(we2), .be_o(be2),
        .aid_o(aid2), .a_optional_o(opt2), .other_ecc_o(ecc2), .inj_done_o(done2)
    );

    relobi_a_other_enc_pipe #(.Cfg(TbCfg), .a_optional_t(logic), .NumSegments(1), .PipeEn(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt0), .we_i(we), .be_i(be), .aid_i(aid),
        .a_optional_i(opt), .inj_i(inj), .req_o(req0), .gnt_i(gnt), .we_o(we0), .be_o(be0),
        .aid_o(aid0), .a_optional_o(opt0), .other_ecc_o(ecc0), .inj_done_o(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream handshakes of u_dut1, sampled mid-cycle
    always @(negedge clk) begin
        if (req1 && gnt) n_hs1++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, return at the falling edge
    task automatic beat(input logic r, input logic w, input logic [3:0] b, input logic [3:0] a,
                        input logic i, input logic g);
        @(posedge clk);
        #1;
        req = r; we = w; be = b; aid = a; opt = 1'b0; inj = i; gnt = g;
        @(negedge clk);
    endtask

    // Hand-computed Hsiao parity for beats {we=0, be=0, aid=i, opt=0}
    logic [4:0] exp1 [4] = '{5'h00, 5'h0B, 5'h0D, 5'h06};
    logic [9:0] exp2 [4] = '{10'h000, 10'h00B, 10'h00D, 10'h006};

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; aid = '0; opt = 1'b0; inj = 1'b0; gnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req1", req1, 1'b0);
        chk("rst_gnt1", gnt1, 1'b1);
        chk("rst_gnt0", gnt0, 1'b1);
        chk("rst_done1", done1, 1'b0);
        chk("rst_ecc1", ecc1, 5'h00);
        chk("rst_ecc2", ecc2, 10'h000);
        chk("rst_pay1", {we1, be1, aid1, opt1}, 10'h000);
        @(posedge clk);
        #1;
        rst = 1'b0; gnt = 1'b1;
        @(negedge clk);
        chk("post_rst_req1", req1, 1'b0);
        chk("post_rst_gnt1", gnt1, 1'b1);

        // Single beat 10'b1_1111_0011_0
        beat(1'b1, 1'b1, 4'hF, 4'h3, 1'b0, 1'b1);
        chk("lat_req1", req1, 1'b0);
        chk("lat_gnt1", gnt1, 1'b1);
        chk("comb_req0", req0, 1'b1);
        chk("comb_ecc0", ecc0, 5'h1A);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("one_req1", req1, 1'b1);
        chk("one_pay1", {we1, be1, aid1, opt1}, 10'b1_1111_0011_0);
        chk("one_ecc1", ecc1, 5'h1A);
        chk("one_ecc2", ecc2, 10'h386);
        chk("one_done1", done1, 1'b0);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("one_empty_req1", req1, 1'b0);

        // Back-to-back
        hs0 = n_hs1;
        for (int i = 0; i < 5; i++) begin
            beat(i < 4, 1'b0, 4'h0, 4'(i), 1'b0, 1'b1);
            if (i < 4) chk("b2b_gnt1", gnt1, 1'b1);
            if (i > 0) begin
                chk("b2b_req1", req1, 1'b1);
                chk("b2b_aid1", aid1, 4'(i - 1));
                chk("b2b_ecc1", ecc1, exp1[i-1]);
                chk("b2b_ecc2", ecc2, exp2[i-1]);
            end
        end
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("b2b_end_req1", req1, 1'b0);
        chk("b2b_count", n_hs1 - hs0, 4);

        // Stall: beat A (we only) held downstream, beat B (aid=1) waits upstream
        hs0 = n_hs1;
        beat(1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("stl_gnt1_empty", gnt1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
            chk("stl_req1", req1, 1'b1);
            chk("stl_gnt1", gnt1, 1'b0);
            chk("stl_pay1", {we1, be1, aid1, opt1}, 10'b1_0000_0000_0);
            chk("stl_ecc1", ecc1, 5'h1C);
            chk("stl_ecc2", ecc2, 10'h260);
        end
        beat(1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b1);
        chk("rel_gnt1", gnt1, 1'b1);
        chk("rel_we1", we1, 1'b1);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("rel_req1", req1, 1'b1);
        chk("rel_pay1", {we1, be1, aid1, opt1}, 10'b0_0000_0001_0);
        chk("rel_ecc1", ecc1, 5'h0B);
        chk("rel_ecc2", ecc2, 10'h00B);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("rel_end_req1", req1, 1'b0);
        chk("stl_count", n_hs1 - hs0, 2);

        // Injection: arm, re-arm while armed, then two beats
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        chk("inj_idle_done1", done1, 1'b0);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        chk("inj_idle_req1", req1, 1'b0);
        beat(1'b1, 1'b0, 4'h0, 4'h2, 1'b0, 1'b1);
        chk("inj_ecc0", ecc0, 5'h0C);
        chk("inj_done0", done0, 1'b1);
        chk("inj_req1", req1, 1'b0);
        beat(1'b1, 1'b0, 4'h0, 4'h3, 1'b0, 1'b1);
        chk("inj_aid1", aid1, 4'h2);
        chk("inj_ecc1", ecc1, 5'h0C);
        chk("inj_done1", done1, 1'b1);
        chk("inj_ecc2", ecc2, 10'h00C);
        chk("inj_done2", done2, 1'b1);
        chk("clean_ecc0", ecc0, 5'h06);
        chk("clean_done0", done0, 1'b0);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("clean_aid1", aid1, 4'h3);
        chk("clean_ecc1", ecc1, 5'h06);
        chk("clean_done1", done1, 1'b0);
        chk("clean_ecc2", ecc2, 10'h006);
        // Injection in the same cycle as the handshake
        beat(1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 1'b1);
        chk("same_ecc0", ecc0, 5'h0A);
        chk("same_done0", done0, 1'b1);
        beat(1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b1);
        chk("same_ecc1", ecc1, 5'h0A);
        chk("same_done1", done1, 1'b1);
        chk("after_ecc0", ecc0, 5'h0B);
        chk("after_done0", done0, 1'b0);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("after_ecc1", ecc1, 5'h0B);
        chk("after_done1", done1, 1'b0);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("inj_end_req1", req1, 1'b0);

        // Reset while a beat is stalled downstream
        hs0 = n_hs1;
        beat(1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("rs_gnt1", gnt1, 1'b1);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("rs_req1", req1, 1'b1);
        chk("rs_ecc1", ecc1, 5'h1C);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rs_during_req1", req1, 1'b0);
        chk("rs_during_gnt1", gnt1, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0; gnt = 1'b1;
        @(negedge clk);
        chk("rs_after_req1", req1, 1'b0);
        chk("rs_after_pay1", {we1, be1, aid1, opt1}, 10'h000);
        chk("rs_after_ecc1", ecc1, 5'h00);
        chk("rs_after_gnt1", gnt1, 1'b1);
        beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        chk("rs_late_req1", req1, 1'b0);
        chk("rs_count", n_hs1 - hs0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/relobi_a_other_enc_pipe.md
RELOBI_A_OTHER_ENC_PIPE -- requirements
Module: relobi_a_other_enc_pipe

Interface
REQ-001 SHALL have parameter Cfg, obi_pkg::obi_cfg_t, default obi_pkg::ObiDefaultConfig: bus configuration.
REQ-002 SHALL have parameter a_optional_t, type, default logic: optional A-channel payload.
REQ-003 SHALL have parameter NumSegments, int unsigned, default 1: independent Hsiao segments, legal 1..4.
REQ-004 SHALL have parameter PipeEn, bit, default 1: 1 = registered stage, 0 = combinational pass.
REQ-005 SHALL have parameter OtherEccWidth, int unsigned, default relobi_pkg::relobi_a_other_seg_ecc_width(Cfg, NumSegments): total ECC bits.
REQ-006 SHALL have ports clk_i in 1 (clock), rst_i in 1 (synchronous, active-high reset).
REQ-007 SHALL have ports req_i in 1 and gnt_o out 1: upstream handshake.
REQ-008 SHALL have input payload ports we_i 1, be_i Cfg.DataWidth/8, aid_i Cfg.IdWidth, a_optional_i a_optional_t.
REQ-009 SHALL have port inj_i in 1: arms single-beat ECC error injection.
REQ-010 SHALL have ports req_o out 1 and gnt_i in 1: downstream handshake.
REQ-011 SHALL have outputs we_o, be_o, aid_o, a_optional_o (widths as inputs) and other_ecc_o out OtherEccWidth.
REQ-012 SHALL have output inj_done_o out 1: pulse when an injected beat is accepted downstream.

Function
REQ-013 SHALL concatenate {we_i, be_i, aid_i, a_optional_i} (MSB first) into a vector of width W = relobi_a_other_width(Cfg).
REQ-014 SHALL split the vector into NumSegments slices, LSB first, each of ceil(W/NumSegments) bits, with the last slice taking the remainder.
REQ-015 SHALL encode each slice with its own Hsiao SEC-DED encoder and keep only the parity bits; segment 0 parity is placed at the LSBs of other_ecc_o.
REQ-016 SHALL size each segment's parity as the smallest k with 2^(k-1) >= d+k, where d is the slice width.
REQ-017 PipeEn=1: SHALL compute the ECC before the register and store payload and ECC in one entry; latency is 1 cycle.
REQ-018 PipeEn=1: SHALL drive req_o = valid_q, gnt_o = !valid_q || gnt_i, so back-to-back throughput is 1 beat per cycle.
REQ-019 PipeEn=1: entry SHALL load on req_i && gnt_o and clear on gnt_i && !req_i; outputs SHALL hold stable while req_o && !gnt_i.
REQ-020 PipeEn=0: SHALL drive req_o = req_i, gnt_o = gnt_i, outputs combinationally from inputs; latency 0.
REQ-021 SHALL set an armed flag when inj_i=1; the flag clears on the next upstream handshake.
REQ-022 The beat accepted while armed, or in the same cycle as inj_i, SHALL have other_ecc_o bit 0 inverted; all other beats are unmodified.
REQ-023 inj_i=1 while armed SHALL be ignored: one injection, not queued.
REQ-024 SHALL carry the inject mark with the entry and pulse inj_done_o for one cycle on req_o && gnt_i of the marked beat.
REQ-025 SHALL keep req_o low while the entry is empty; an upstream req_i with gnt_o low SHALL NOT be lost or duplicated.

Reset
REQ-026 On rst_i=1 at a clock edge, SHALL clear valid_q, the armed flag and the inject mark.
REQ-027 During and after reset, SHALL drive req_o=0, inj_done_o=0 and gnt_o=1; payload and ECC outputs SHALL be 0.
REQ-028 Reset during a stalled beat SHALL drop the beat without a downstream handshake.

Structure
REQ-029 relobi_pkg SHALL hold relobi_a_other_width, relobi_a_other_seg_ecc_width and a segment-width helper function.
REQ-030 SHALL instantiate NumSegments copies of hsiao_ecc_enc in a generate loop.
REQ-031 A sub-module relobi_a_other_seg_enc, wrapping one segment, is natural.
REQ-032 SHALL assert at elaboration that 1 <= NumSegments <= 4 and NumSegments <= W.

Verification (bench configuration: DataWidth 32, IdWidth 4, a_optional_t logic, so W=10)
REQ-033 NumSegments=1, PipeEn=1: one beat we=1, be=4'hF, aid=4'h3, opt=0 -> req_o one cycle later; other_ecc_o (5 bits) equals the reference Hsiao parity of 10'b1_1111_0011_0.
REQ-034 NumSegments=2: same beat -> OtherEccWidth=10; each 5-bit half equals the parity of its own 5-bit slice.
REQ-035 Back-to-back: 4 beats with gnt_i=1 throughout -> 4 outputs on 4 consecutive cycles, in order, gnt_o constantly 1.
REQ-036 Stall: gnt_i=0 for 3 cycles with req_i held -> gnt_o=0, outputs stable; after release both beats delivered once each.
REQ-037 Injection: inj_i pulse, then 2 beats -> first beat ECC bit 0 inverted with inj_done_o pulsed on its acceptance; second beat clean; a second inj_i while armed has no effect.
REQ-038 Reset with a stalled entry -> req_o=0 the next cycle and the beat is never emitted.
